// File: rtl/arc4_pkg.sv
// Shared ARC4 definitions: byte type, PRGA state encoding and the printable-ASCII window.
// No logic of its own; the window bounds are reused by the key-cracking stage.
// The printable check helper is only referenced when PRGA_ASCII_CHECK_EN is defined.
package arc4_pkg;

    typedef logic [7:0] byte_t;

    typedef enum logic [3:0] {
        PRGA_IDLE   = 4'd0,
        PRGA_LEN_RD = 4'd1,
        PRGA_LEN_WR = 4'd2,
        PRGA_S_I    = 4'd3,
        PRGA_S_J    = 4'd4,
        PRGA_W_I    = 4'd5,
        PRGA_W_J    = 4'd6,
        PRGA_PAD    = 4'd7,
        PRGA_OUT    = 4'd8
    } prga_state_t;

    localparam byte_t ASCII_LO = 8'h20;
    localparam byte_t ASCII_HI = 8'h7E;

    function automatic logic is_printable(input byte_t b);
        return (b >= ASCII_LO) && (b <= ASCII_HI);
    endfunction

endpackage

// File: rtl/prga.sv
// RC4 PRGA: decrypts length-prefixed ct memory into pt using the permuted S RAM.
// Latency: rdy low for 2+6L cycles (L = ct[0]); one S/ct/pt access per state, reads consumed next state.
// No backpressure: en is sampled only while rdy=1; PRGA_ASCII_CHECK_EN adds an abort on non-printable output.
module prga
    import arc4_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    output logic  rdy,
    output logic  ok,
    output byte_t s_addr,
    input  byte_t s_rddata,
    output byte_t s_wrdata,
    output logic  s_wren,
    output byte_t ct_addr,
    input  byte_t ct_rddata,
    output byte_t pt_addr,
    output byte_t pt_wrdata,
    output logic  pt_wren
);

    prga_state_t state_q, state_d;
    byte_t       i_q, i_d;
    byte_t       j_q, j_d;
    byte_t       si_q, si_d;
    byte_t       sj_q, sj_d;
    byte_t       k_q, k_d;
    byte_t       len_q, len_d;
    byte_t       pt_byte;

`ifdef PRGA_ASCII_CHECK_EN
    logic        ok_q, ok_d;
    assign ok = ok_q;
`else
    assign ok = 1'b1;
`endif

    assign rdy     = (state_q == PRGA_IDLE);
    assign pt_byte = s_rddata ^ ct_rddata;

    // Next-state, datapath update and memory-port drive for the byte loop
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        si_d      = si_q;
        sj_d      = sj_q;
        k_d       = k_q;
        len_d     = len_q;
`ifdef PRGA_ASCII_CHECK_EN
        ok_d      = ok_q;
`endif
        s_addr    = 8'd0;
        s_wrdata  = 8'd0;
        s_wren    = 1'b0;
        ct_addr   = 8'd0;
        pt_addr   = 8'd0;
        pt_wrdata = 8'd0;
        pt_wren   = 1'b0;
        case (state_q)
            PRGA_IDLE: begin
                if (en) begin
                    state_d = PRGA_LEN_RD;
                    i_d     = 8'd0;
                    j_d     = 8'd0;
                    k_d     = 8'd0;
`ifdef PRGA_ASCII_CHECK_EN
                    ok_d    = 1'b1;
`endif
                end
            end
            PRGA_LEN_RD: begin
                ct_addr = 8'd0;
                state_d = PRGA_LEN_WR;
            end
            PRGA_LEN_WR: begin
                len_d     = ct_rddata;
                pt_addr   = 8'd0;
                pt_wrdata = ct_rddata;
                pt_wren   = 1'b1;
                state_d   = (ct_rddata == 8'd0) ? PRGA_IDLE : PRGA_S_I;
            end
            PRGA_S_I: begin
                i_d     = i_q + 8'd1;
                s_addr  = i_q + 8'd1;
                state_d = PRGA_S_J;
            end
            PRGA_S_J: begin
                si_d    = s_rddata;
                j_d     = j_q + s_rddata;
                s_addr  = j_q + s_rddata;
                state_d = PRGA_W_I;
            end
            PRGA_W_I: begin
                // i==j needs no special case: the W_J write of si lands last
                sj_d     = s_rddata;
                s_addr   = i_q;
                s_wrdata = s_rddata;
                s_wren   = 1'b1;
                state_d  = PRGA_W_J;
            end
            PRGA_W_J: begin
                s_addr   = j_q;
                s_wrdata = si_q;
                s_wren   = 1'b1;
                state_d  = PRGA_PAD;
            end
            PRGA_PAD: begin
                s_addr  = si_q + sj_q;
                ct_addr = k_q + 8'd1;
                state_d = PRGA_OUT;
            end
            PRGA_OUT: begin
                pt_addr   = k_q + 8'd1;
                pt_wrdata = pt_byte;
                pt_wren   = 1'b1;
                k_d       = k_q + 8'd1;
                state_d   = ((k_q + 8'd1) == len_q) ? PRGA_IDLE : PRGA_S_I;
`ifdef PRGA_ASCII_CHECK_EN
                // the offending byte is still written; the run just stops here
                if (!is_printable(pt_byte)) begin
                    ok_d    = 1'b0;
                    state_d = PRGA_IDLE;
                end
`endif
            end
            default: state_d = PRGA_IDLE;
        endcase
    end

    // State and byte registers; reset parks the block idle with ok set
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PRGA_IDLE;
            i_q     <= 8'd0;
            j_q     <= 8'd0;
            si_q    <= 8'd0;
            sj_q    <= 8'd0;
            k_q     <= 8'd0;
            len_q   <= 8'd0;
`ifdef PRGA_ASCII_CHECK_EN
            ok_q    <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            k_q     <= k_d;
            len_q   <= len_d;
`ifdef PRGA_ASCII_CHECK_EN
            ok_q    <= ok_d;
`endif
        end
    end

endmodule

// File: tb/tb_prga.sv
// Directed bench for prga: behavioural S/ct/pt memories, software RC4 model feeding
// an expected-write queue, and counters for rdy-low cycles and S writes.
// Compile with PRGA_ASCII_CHECK_EN to exercise the printable-abort build.
module tb_prga;
    import arc4_pkg::*;

`ifdef PRGA_ASCII_CHECK_EN
    localparam bit ASCII_EN = 1'b1;
`else
    localparam bit ASCII_EN = 1'b0;
`endif

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  en  = 1'b0;
    logic  rdy, ok, s_wren, pt_wren;
    byte_t s_addr, s_rddata, s_wrdata, ct_addr, ct_rddata, pt_addr, pt_wrdata;

    always #5 clk = ~clk;

    prga dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rdy       (rdy),
        .ok        (ok),
        .s_addr    (s_addr),
        .s_rddata  (s_rddata),
        .s_wrdata  (s_wrdata),
        .s_wren    (s_wren),
        .ct_addr   (ct_addr),
        .ct_rddata (ct_rddata),
        .pt_addr   (pt_addr),
        .pt_wrdata (pt_wrdata),
        .pt_wren   (pt_wren)
    );

    byte_t s_mem  [256];
    byte_t s_init [256];
    byte_t ms     [256];
    byte_t ct_mem [256];
    byte_t pt_mem [256];
    logic  load_s = 1'b0;

    int    rdy_low_cnt = 0;
    int    s_wr_cnt    = 0;
    int    act_n       = 0;
    byte_t act_addr [2048];
    byte_t act_data [2048];

    logic [15:0] exp_q [$];
    int    n_vec = 0;
    int    n_err = 0;

    // synchronous-read memories around the DUT
    always @(posedge clk) begin
        if (load_s) begin
            for (int x = 0; x < 256; x++) s_mem[x] <= s_init[x];
        end else if (s_wren) begin
            s_mem[s_addr] <= s_wrdata;
        end
        s_rddata  <= s_mem[s_addr];
        ct_rddata <= ct_mem[ct_addr];
        if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
    end

    // observe busy cycles and writes away from the active edge
    always @(negedge clk) begin
        if (!rdy) rdy_low_cnt <= rdy_low_cnt + 1;
        if (s_wren) s_wr_cnt <= s_wr_cnt + 1;
        if (pt_wren && act_n < 2048) begin
            act_addr[act_n] <= pt_addr;
            act_data[act_n] <= pt_wrdata;
            act_n           <= act_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic load_identity();
        for (int x = 0; x < 256; x++) s_init[x] = 8'(x);
    endtask

    task automatic load_ksa();
        byte_t key [3];
        byte_t j, t;
        key[0] = 8'h00; key[1] = 8'h03; key[2] = 8'h3C;
        load_identity();
        j = 8'd0;
        for (int x = 0; x < 256; x++) begin
            j = j + s_init[x] + key[x % 3];
            t = s_init[x]; s_init[x] = s_init[j]; s_init[j] = t;
        end
    endtask

    task automatic push_s();
        @(negedge clk); load_s = 1'b1;
        @(negedge clk); load_s = 1'b0;
        ms = s_init;
    endtask

    // software RC4 over ms; pushes the expected pt writes (header first)
    task automatic model(input bit use_ascii, output int nbytes, output bit eok);
        byte_t i, j, si, sj, p, l;
        l = ct_mem[0]; i = 8'd0; j = 8'd0; nbytes = 0; eok = 1'b1;
        exp_q.push_back({8'h00, l});
        for (int k = 0; k < int'(l); k++) begin
            i = i + 8'd1;
            si = ms[i];
            j = j + si;
            sj = ms[j];
            ms[i] = sj;
            ms[j] = si;
            p = ms[8'(si + sj)] ^ ct_mem[k + 1];
            exp_q.push_back({8'(k + 1), p});
            nbytes++;
            if (use_ascii && ASCII_EN && !is_printable(p)) begin
                eok = 1'b0;
                break;
            end
        end
    endtask

    // choose ct so every plaintext byte is a letter
    task automatic make_printable(input int l);
        int    nb;
        bit    eo;
        logic [15:0] e;
        ct_mem[0] = 8'(l);
        for (int k = 1; k <= l; k++) ct_mem[k] = 8'h00;
        ms = s_init;
        model(1'b0, nb, eo);
        e = exp_q.pop_front();
        for (int k = 0; k < l; k++) begin
            e = exp_q.pop_front();
            ct_mem[k + 1] = e[7:0] ^ 8'(8'h41 + (k % 26));
        end
        exp_q.delete();
        ms = s_init;
    endtask

    task automatic run(input int mid_en_at, input int rst_at,
                       output int cyc, output int swr, output int base);
        int rl0, sw0;
        bit done;
        rl0 = rdy_low_cnt; sw0 = s_wr_cnt; base = act_n; done = 1'b0;
        @(negedge clk); en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            en = (c == mid_en_at);
            if (c == rst_at) chk("rst_point_in_wj_s_wren", 32'(s_wren), 32'd1);
            rst = (c == rst_at);
            if (rdy) begin
                done = 1'b1;
                break;
            end
        end
        en = 1'b0; rst = 1'b0;
        chk("run_completes_in_budget", 32'(done), 32'd1);
        #1;
        cyc = rdy_low_cnt - rl0;
        swr = s_wr_cnt - sw0;
    endtask

    task automatic check_pt(input string tag, input int base);
        int idx;
        logic [15:0] e;
        idx = base;
        chk({tag, "_pt_write_count"}, 32'(act_n - base), 32'(exp_q.size()));
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (idx < act_n) begin
                chk({tag, "_pt_addr"}, 32'(act_addr[idx]), 32'(e[15:8]));
                chk({tag, "_pt_data"}, 32'(act_data[idx]), 32'(e[7:0]));
            end
            idx++;
        end
    endtask

    task automatic check_s(input string tag);
        int d;
        d = 0;
        for (int x = 0; x < 256; x++) if (s_mem[x] !== ms[x]) d++;
        chk({tag, "_s_diff_entries"}, 32'(d), 32'd0);
    endtask

    initial begin
        int cyc, swr, base, nb;
        bit eok;

        for (int x = 0; x < 256; x++) ct_mem[x] = 8'h00;

        // reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rdy", 32'(rdy), 32'd1);
        chk("reset_ok", 32'(ok), 32'd1);
        chk("reset_s_addr", 32'(s_addr), 32'd0);
        chk("reset_s_wrdata", 32'(s_wrdata), 32'd0);
        chk("reset_s_wren", 32'(s_wren), 32'd0);
        chk("reset_ct_addr", 32'(ct_addr), 32'd0);
        chk("reset_pt_addr", 32'(pt_addr), 32'd0);
        chk("reset_pt_wrdata", 32'(pt_wrdata), 32'd0);
        chk("reset_pt_wren", 32'(pt_wren), 32'd0);
        rst = 1'b0;

        // zero-length message
        load_identity(); push_s();
        ct_mem[0] = 8'd0;
        model(1'b1, nb, eok);
        run(-1, -1, cyc, swr, base);
        chk("len0_busy_cycles", 32'(cyc), 32'd2);
        chk("len0_s_writes", 32'(swr), 32'd0);
        chk("len0_pt0", 32'(pt_mem[0]), 32'd0);
        check_pt("len0", base);

        // identity S, two bytes
        load_identity(); push_s();
        ct_mem[0] = 8'd2; ct_mem[1] = 8'h41; ct_mem[2] = 8'h00;
        model(1'b1, nb, eok);
        run(-1, -1, cyc, swr, base);
        chk("id2_busy_cycles", 32'(cyc), 32'd14);
        chk("id2_s_writes", 32'(swr), 32'd4);
        chk("id2_pt1", 32'(pt_mem[1]), 32'h43);
        chk("id2_pt2", 32'(pt_mem[2]), 32'h05);
        chk("id2_s2_after_swap", 32'(s_mem[2]), 32'h03);
        chk("id2_s3_after_swap", 32'(s_mem[3]), 32'h02);
        chk("id2_ok", 32'(ok), ASCII_EN ? 32'd0 : 32'd1);
        chk("id2_ok_model", 32'(ok), 32'(eok));
        check_pt("id2", base);

        // identity S, last byte lands exactly on the printable floor
        load_identity(); push_s();
        ct_mem[2] = 8'h25;
        model(1'b1, nb, eok);
        run(-1, -1, cyc, swr, base);
        chk("id2p_pt2", 32'(pt_mem[2]), 32'h20);
        chk("id2p_ok", 32'(ok), 32'd1);
        check_pt("id2p", base);

        // full-length message on a KSA-permuted S
        load_ksa(); push_s();
        ct_mem[0] = 8'd255;
        for (int k = 1; k < 256; k++) ct_mem[k] = 8'($urandom);
        model(1'b1, nb, eok);
        run(-1, -1, cyc, swr, base);
        chk("full_busy_cycles", 32'(cyc), 32'(2 + 6 * nb));
        chk("full_s_writes", 32'(swr), 32'(2 * nb));
        chk("full_ok", 32'(ok), 32'(eok));
        check_pt("full", base);
        check_s("full");

        // en pulsed while busy is ignored
        load_ksa(); push_s();
        make_printable(10);
        model(1'b1, nb, eok);
        run(7, -1, cyc, swr, base);
        chk("miden_busy_cycles", 32'(cyc), 32'd62);
        chk("miden_s_writes", 32'(swr), 32'd20);
        check_pt("miden", base);

        // reset during the second byte's W_J, then a clean rerun
        load_ksa(); push_s();
        make_printable(20);
        run(-1, 11, cyc, swr, base);
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_s_wren", 32'(s_wren), 32'd0);
        chk("rst_pt_wren", 32'(pt_wren), 32'd0);
        chk("rst_ok", 32'(ok), 32'd1);
        chk("rst_busy_cycles", 32'(cyc), 32'd12);
        push_s();
        model(1'b1, nb, eok);
        run(-1, -1, cyc, swr, base);
        chk("rerun_busy_cycles", 32'(cyc), 32'd122);
        chk("rerun_s_writes", 32'(swr), 32'd40);
        chk("rerun_ok", 32'(ok), 32'd1);
        check_pt("rerun", base);
        check_s("rerun");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/prga.md
# prga

RC4 pseudo-random generation stage: runs after init/KSA have left the permuted state array S in on-chip RAM, walks the length-prefixed ciphertext memory, and writes the decrypted plaintext memory. It is a leaf under the ARC4 top, downstream of `ksa`. It shares the S RAM port with init/KSA through the top-level mux and uses the same `en`/`rdy` start handshake as its siblings.

## Interface
Parameters:
- none. Byte width and memory depth are fixed at 8 bits and 256 entries.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  start request; sampled only while `rdy`=1.
- `rdy`  out  1  idle/ready flag. Reset value 1.
- `ok`  out  1  plaintext-valid flag (see Configuration). Reset value 1.
- `s_addr`  out  8  S RAM address. Reset value 0.
- `s_rddata`  in  8  S RAM read data, valid one cycle after the address.
- `s_wrdata`  out  8  S RAM write data. Reset value 0.
- `s_wren`  out  1  S RAM write enable. Reset value 0.
- `ct_addr`  out  8  ciphertext ROM address. Reset value 0.
- `ct_rddata`  in  8  ciphertext read data, 1-cycle latency.
- `pt_addr`  out  8  plaintext RAM address. Reset value 0.
- `pt_wrdata`  out  8  plaintext write data. Reset value 0.
- `pt_wren`  out  1  plaintext write enable. Reset value 0.

## Operation
- Memory format: ct[0] = length L (0..255). ct[1..L] hold the message bytes. pt is written in the same format.
- Handshake: `en`=1 while `rdy`=1 starts a run, and `rdy` drops the next cycle. While `rdy`=0, `en` is ignored. `rdy` returns to 1 only when the run completes or aborts.
- Registers: i, j, si, sj, k. i, j and k are cleared to 0 at start. All arithmetic is 8-bit modulo 256 with the carry dropped.
- State sequence:
  - IDLE.
  - LEN_RD: ct_addr=0.
  - LEN_WR: capture L; pt[0]=L. If L=0, return to IDLE.
  - Per byte, repeated L times:
    - S_I: i←i+1; s_addr=i+1.
    - S_J: si←s_rddata; j←j+si; s_addr=j+si.
    - W_I: sj←s_rddata; write S[i]←sj.
    - W_J: write S[j]←si.
    - PAD: s_addr=si+sj; ct_addr=k+1.
    - OUT: pt[k+1]←s_rddata XOR ct_rddata; k←k+1. Go to IDLE if k+1=L, else go to S_I.
- When i=j, the two swap writes go to the same address, and the final value is si. This is correct RC4 behaviour and needs no special case.
- Write enables are high for exactly one cycle per write and are 0 in every other state.
- `rst` mid-run: the next state is IDLE, `rdy`=1, all wren=0, and `ok`=1. Partially written S and pt contents are left as-is.

## Timing
- Read latency: every read is issued in one state and consumed in the next state.
- A run with length L holds `rdy`=0 for exactly 2+6L cycles:
  - L=0: 2 cycles.
  - L=255: 1532 cycles.
- Exactly one pt write per message byte plus the header write.
- S writes per run: 2L.

## Configuration
- `PRGA_ASCII_CHECK_EN` defined:
  - In OUT, a plaintext byte outside 0x20..0x7E clears `ok` and the block returns to IDLE at once, without writing further bytes.
  - The offending byte itself is still written.
  - `ok` is set to 1 at each start.
  - This flag is used by the key-cracking stage that runs after this block.
- Macro undefined: `ok` is constant 1, and all L bytes are always processed.

## Structure
- Shared package `arc4_pkg` holds:
  - `byte_t` typedef.
  - The PRGA state enum.
  - The constants `ASCII_LO`=8'h20 and `ASCII_HI`=8'h7E, which are reused by the cracking stage.
- The block is a single flat module with no sub-module. The datapath is a handful of byte registers next to a single FSM.

## Test plan
- Length 0: ct[0]=0 → pt[0]=0 and `rdy`=0 for exactly 2 cycles. There are no S writes.
- Identity S (S[x]=x), L=2, ct[1]=0x41, ct[2]=0x00:
  - pt[1]=0x43 (pad S[2]=2).
  - pt[2]=0x05. For this byte, j=3, S[2]=3 and S[3]=2 after the swap, and the pad is S[5].
  - `rdy` low for 14 cycles.
- With `PRGA_ASCII_CHECK_EN`, same stimulus → `ok`=0 after byte 2. With ct[2]=0x25 instead, pt[2]=0x20 and `ok`=1.
- Full pass after KSA with key 24'h00033C, L=255 → `rdy` low for 1532 cycles. Each pt[k] matches the software RC4 model. j wraps past 255 with no out-of-range address.
- `en` pulsed mid-run → ignored; the pt write count is unchanged.
- `rst` asserted during W_J → next cycle `rdy`=1 and all wren=0. A fresh `en` then reruns correctly on a reloaded S.
